dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory (DMEM) between the CPU core and a secondary word-access master (loader, debug reader or display scanner). It sits between `cpu` and `DMEM` inside the top-level dataflow module. It owns the DMEM control, address and write-data pins. The CPU keeps fixed priority; the secondary port uses a req/ack handshake. An optional anti-starvation guard stalls the CPU for one cycle.

## Interface
- `ADDR_W`, 11, word address width (byte address bits [12:2])
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 8, blocked cycles before a forced grant (guard build only; ≥1)

- `clk` in 1 — system clock, rising edge
- `reset` in 1 — asynchronous, active-low; 0 = reset
- `cpu_cs` in 1 — CPU DMEM chip select
- `cpu_r` in 1 — CPU read strobe
- `cpu_w` in 1 — CPU write strobe
- `cpu_addr` in ADDR_W — CPU word address
- `cpu_wdata` in DATA_W — CPU write data
- `cpu_rdata` out DATA_W — `dmem_rdata` passthrough
- `cpu_stall` out 1 — CPU must hold PC and retry its access
- `p1_req` in 1 — secondary request
- `p1_we` in 1 — 1 = write, 0 = read
- `p1_addr` in ADDR_W — secondary word address
- `p1_wdata` in DATA_W — secondary write data
- `p1_ack` out 1 — one-cycle completion pulse
- `p1_rdata` out DATA_W — registered read data, valid with `p1_ack`
- `dmem_cs`, `dmem_r`, `dmem_w` out 1 — DMEM controls
- `dmem_addr` out ADDR_W; `dmem_wdata` out DATA_W — DMEM address and write data
- `dmem_rdata` in DATA_W — DMEM combinational read data

## Operation
- States: `IDLE`, `FORCE`, `ACK`.
- DMEM timing: reads are combinational; writes commit on the `clk` edge.
- **`IDLE`**
  - `cpu_cs`=1: CPU signals are muxed to DMEM.
  - `cpu_cs`=0 and `p1_req`=1: the p1 access is driven to DMEM this cycle (`dmem_cs`=1, `dmem_w`=`p1_we`, `dmem_r`=~`p1_we`). On the edge, the write commits or `dmem_rdata` is captured into `p1_rdata`. Next state is `ACK`.
  - `cpu_cs`=1 and `p1_req`=1: p1 is blocked and `wait_cnt` increments.
- **`ACK`**
  - `p1_ack`=1 for exactly one cycle.
  - p1 is not granted here; the CPU is muxed normally.
  - Always returns to `IDLE`.
  - If `p1_req` is still high in `ACK`, it is treated as a new request from the next cycle on.
- **`FORCE`** (guard build only)
  - `cpu_stall`=1 and p1 owns DMEM, exactly as a grant.
  - Next state is `ACK`.
- Handshake: the requester holds `p1_we`, `p1_addr` and `p1_wdata` stable from raising `p1_req` until it sees `p1_ack`. `p1_rdata` holds its value until the next p1 read completes.
- `wait_cnt` clears on every p1 grant and whenever `p1_req`=0.
- Same-address collision: the CPU write wins its cycle and the later p1 write overwrites it.
- DMEM idle: all `dmem_*` strobes are 0 when no owner exists.

## Timing
- Reset (`reset`=0, asynchronous), every output:
  - state=`IDLE`, `wait_cnt`=0
  - `p1_ack`=0, `p1_rdata`=0, `cpu_stall`=0
  - `dmem_cs`=`dmem_r`=`dmem_w`=0 (gated combinationally while in reset)
  - `cpu_rdata` still passes `dmem_rdata`
- Reset mid-access: the in-flight p1 access is abandoned with no ack; a write already committed on a prior edge stays committed.
- p1 latency (ack rises in the cycle after the grant):
  - Unblocked: grant in the first cycle `p1_req` is high; `p1_ack` the next cycle.
  - Back-to-back with `p1_req` held: max throughput is one access every 2 cycles.
- `cpu_stall` and the `dmem_*` mux are decoded combinationally from state and inputs; `p1_ack` and `p1_rdata` are registered.
- Guard build:
  - A blocked `IDLE` cycle with `wait_cnt`==`STARVE_LIMIT`-1 moves to `FORCE`.
  - Result: `STARVE_LIMIT` blocked cycles, `FORCE` in the next cycle, `p1_ack` in the cycle after that.
  - `cpu_stall` is high for exactly one cycle per forced grant.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined: `wait_cnt`, the `FORCE` state and `cpu_stall` are active as described.
- Not defined:
  - Strict CPU priority; `FORCE` and the counter are not built.
  - `cpu_stall` is tied to 0.
  - p1 is served only in cycles with `cpu_cs`=0 and can starve indefinitely.

## Test plan
- Reset: drive `p1_req`=1, `p1_we`=1 (write) with `cpu_cs`=0, and pull `reset`=0 in the grant cycle -> `p1_ack`=0, state `IDLE`, `p1_rdata`=0, `dmem_cs`=0 while held.
- Write/read: `cpu_cs`=0; p1 write 0xDEADBEEF to 0x010 -> `p1_ack` one cycle after grant. Then p1 read of 0x010 -> `p1_rdata`=0xDEADBEEF with `p1_ack`.
- Priority collision: CPU writes 0x00001234 to 0x020 in the same cycle p1 requests a write of 0x00005678 to 0x020; `cpu_cs` drops the next cycle. Required: CPU write committed first, p1 granted the following cycle, final read of 0x020 = 0x00005678.
- Starvation, guard build, `STARVE_LIMIT`=8: `cpu_cs`=1 continuously with a p1 read pending -> `cpu_stall`=1 only in cycle 9 after the request, `p1_ack` in cycle 10. Without the macro: no ack after 100 cycles and `cpu_stall` always 0.
- Streaming: `cpu_cs`=0 with `p1_req` held high for 6 cycles -> `p1_ack` pattern 0,1,0,1,0,1 and 3 accesses completed.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single-port DMEM between the CPU (fixed priority) and a secondary req/ack master p1.
// Define DMEM_ARB_STARVE_GUARD_EN to build the anti-starvation guard (wait_cnt, FORCE, cpu_stall).
module dmem_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_cs,
    input  logic              cpu_r,
    input  logic              cpu_w,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              dmem_cs,
    output logic              dmem_r,
    output logic              dmem_w,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [1:0]        dbg_state
);
    // p1 handshake: the requester raises p1_req and holds p1_we/p1_addr/p1_wdata stable until it
    // sees p1_ack, a one-cycle pulse in the cycle after the grant; p1_rdata is valid with p1_ack.
    typedef enum logic [1:0] {IDLE = 2'd0, FORCE = 2'd1, ACK = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              p1_ack_q, p1_ack_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              p1_grant;
    logic              p1_blocked;
    logic              starve_hit;

    assign p1_blocked = (state_q == IDLE) && cpu_cs && p1_req;
    assign p1_grant   = ((state_q == IDLE) && !cpu_cs && p1_req) || (state_q == FORCE);

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    assign starve_hit = p1_blocked && (wait_cnt_q == CNT_W'(STARVE_LIMIT - 1));
    assign cpu_stall  = (state_q == FORCE);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!p1_req || p1_grant) begin
            wait_cnt_d = '0;
        end else if (p1_blocked) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    // Strict CPU priority: p1 waits for a cycle with cpu_cs low, however long that takes.
    assign starve_hit = 1'b0;
    assign cpu_stall  = 1'b0;

    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (p1_grant) begin
                    state_d = ACK;
                end else if (starve_hit) begin
                    state_d = FORCE;
                end
            end
            FORCE:   state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        p1_ack_d   = p1_grant;
        p1_rdata_d = p1_rdata_q;
        if (p1_grant && !p1_we) begin
            p1_rdata_d = dmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            p1_ack_q   <= 1'b0;
            p1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            p1_ack_q   <= p1_ack_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    // Strobes are gated by reset so an in-flight p1 write cannot commit while reset is held.
    assign dmem_cs    = reset && (p1_grant || cpu_cs);
    assign dmem_r     = reset && (p1_grant ? !p1_we : (cpu_cs && cpu_r));
    assign dmem_w     = reset && (p1_grant ?  p1_we : (cpu_cs && cpu_w));
    assign dmem_addr  = p1_grant ? p1_addr  : cpu_addr;
    assign dmem_wdata = p1_grant ? p1_wdata : cpu_wdata;

    assign cpu_rdata = dmem_rdata;
    assign p1_ack    = p1_ack_q;
    assign p1_rdata  = p1_rdata_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized CPU/p1 traffic against a memory model.
// Starvation expectations follow DMEM_ARB_STARVE_GUARD_EN, matching the build of the design.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int ADDR_W       = 11;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 8;
    localparam int DEPTH        = 2048;
    localparam logic [1:0] ST_IDLE = 2'd0;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cpu_cs = 1'b0, cpu_r = 1'b0, cpu_w = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              p1_req = 1'b0, p1_we = 1'b0;
    logic [ADDR_W-1:0] p1_addr = '0;
    logic [DATA_W-1:0] p1_wdata = '0;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;
    logic              dmem_cs, dmem_r, dmem_w;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic [1:0]        dbg_state;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_cs(cpu_cs), .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .dmem_cs(dmem_cs), .dmem_r(dmem_r), .dmem_w(dmem_w), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DMEM: combinational read, write on the edge ----------------
    function automatic logic [DATA_W-1:0] seed_val(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_init_done = 1'b0;

    assign dmem_rdata = mem[dmem_addr];

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= seed_val(i);
            mem_init_done <= 1'b1;
        end else if (dmem_cs && dmem_w) begin
            mem[dmem_addr] <= dmem_wdata;
        end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] last_read = '0;
    logic [DATA_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    bit rand_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every ack must present the p1_rdata the model predicts (read data, or held value after a write).
    always @(negedge clk) begin
        if (reset && p1_ack) begin
            if (exp_q.size() == 0) chk("p1_unexpected_ack", {31'b0, p1_ack}, 32'd0);
            else                   chk("p1_rdata", p1_rdata, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic p1_issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        p1_req   = 1'b1;
        p1_we    = we;
        p1_addr  = addr;
        p1_wdata = wdata;
        if (we) ref_mem[addr] = wdata;
        else    last_read = ref_mem[addr];
        exp_q.push_back(last_read);
    endtask

    task automatic p1_wait_ack(input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (p1_ack) begin
                lat = i;
                break;
            end
        end
        p1_req = 1'b0;
        if (lat == 0) begin
            chk("p1_ack_timeout", {31'b0, p1_ack}, 32'd1);
            void'(exp_q.pop_back());
        end
    endtask

    task automatic cpu_rand();
        while (!rand_done) begin
            step();
            cpu_cs = ($urandom_range(0, 1) == 1);
            cpu_w  = 1'b0;
            cpu_r  = 1'b0;
            if (cpu_cs) begin
                if ($urandom_range(0, 1) == 1) cpu_w = 1'b1;
                else                            cpu_r = 1'b1;
            end
            cpu_addr  = {1'b1, 10'($urandom_range(0, 1023))};
            cpu_wdata = $urandom;
            @(negedge clk);
            if (cpu_cs && !cpu_stall) begin
                if (cpu_w) ref_mem[cpu_addr] = cpu_wdata;
                else       chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr]);
            end
        end
        cpu_cs = 1'b0;
        cpu_r  = 1'b0;
        cpu_w  = 1'b0;
    endtask

    task automatic p1_rand();
        int lat;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            step();
            p1_issue(($urandom_range(0, 1) == 1), ADDR_W'(11'h100 + $urandom_range(0, 15)), $urandom);
            p1_wait_ack(300, lat);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, stall_cnt, stall_at, ack_at, acks;
        logic [5:0] pattern;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_val(i);

        // Reset values while held, CPU reading address 5.
        cpu_cs   = 1'b1;
        cpu_r    = 1'b1;
        cpu_addr = 11'h005;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_p1_ack", {31'b0, p1_ack}, 32'd0);
        chk("reset_p1_rdata", p1_rdata, 32'd0);
        chk("reset_cpu_stall", {31'b0, cpu_stall}, 32'd0);
        chk("reset_dmem_strobes", {29'b0, dmem_cs, dmem_r, dmem_w}, 32'd0);
        chk("reset_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        chk("reset_cpu_rdata", cpu_rdata, seed_val(5));

        step();
        reset  = 1'b1;
        cpu_cs = 1'b0;
        cpu_r  = 1'b0;

        // Load a non-zero p1_rdata so the reset clear is observable.
        step();
        p1_issue(1'b0, 11'h005, '0);
        p1_wait_ack(10, lat);
        chk("rd5_latency", lat, 32'd2);

        // Reset asserted during a p1 write grant cycle.
        step();
        p1_req   = 1'b1;
        p1_we    = 1'b1;
        p1_addr  = 11'h033;
        p1_wdata = 32'hAAAA5555;
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_dmem_cs", {31'b0, dmem_cs}, 32'd0);
        chk("rst_mid_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        chk("rst_mid_p1_rdata", p1_rdata, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_no_ack", {31'b0, p1_ack}, 32'd0);
        end
        step();
        p1_req    = 1'b0;
        reset     = 1'b1;
        last_read = '0;

        // The abandoned write must not have landed.
        step();
        p1_issue(1'b0, 11'h033, '0);
        p1_wait_ack(10, lat);
        chk("rd33_latency", lat, 32'd2);

        // Write then read back through p1.
        step();
        p1_issue(1'b1, 11'h010, 32'hDEADBEEF);
        p1_wait_ack(10, lat);
        chk("wr10_latency", lat, 32'd2);
        step();
        p1_issue(1'b0, 11'h010, '0);
        p1_wait_ack(10, lat);
        chk("rd10_latency", lat, 32'd2);

        // Same-address collision: CPU write first, p1 write the next cycle.
        step();
        cpu_cs    = 1'b1;
        cpu_w     = 1'b1;
        cpu_addr  = 11'h020;
        cpu_wdata = 32'h00001234;
        ref_mem[11'h020] = 32'h00001234;
        p1_issue(1'b1, 11'h020, 32'h00005678);
        @(negedge clk);
        chk("coll_cpu_owns", dmem_wdata, 32'h00001234);
        chk("coll_cpu_w", {31'b0, dmem_w}, 32'd1);
        step();
        cpu_cs = 1'b0;
        cpu_w  = 1'b0;
        @(negedge clk);
        chk("coll_cpu_committed", mem[11'h020], 32'h00001234);
        chk("coll_p1_wdata", dmem_wdata, 32'h00005678);
        p1_wait_ack(5, lat);
        chk("coll_ack_latency", lat, 32'd1);
        step();
        p1_issue(1'b0, 11'h020, '0);
        p1_wait_ack(10, lat);

        // Starvation: CPU selects DMEM every cycle while a p1 read waits.
        step();
        cpu_cs   = 1'b1;
        cpu_r    = 1'b1;
        cpu_addr = 11'h407;
        p1_issue(1'b0, 11'h0AB, '0);
        stall_cnt = 0;
        stall_at  = 0;
        ack_at    = 0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        for (int i = 1; i <= 12; i++) begin
`else
        for (int i = 1; i <= 100; i++) begin
`endif
            @(negedge clk);
            if (cpu_stall) begin
                stall_cnt++;
                stall_at = i;
            end
            if (p1_ack && ack_at == 0) begin
                ack_at = i;
                p1_req = 1'b0;
            end
        end
`ifdef DMEM_ARB_STARVE_GUARD_EN
        chk("starve_stall_count", stall_cnt, 32'd1);
        chk("starve_stall_cycle", stall_at, 32'(STARVE_LIMIT + 1));
        chk("starve_ack_cycle", ack_at, 32'(STARVE_LIMIT + 2));
        step();
        cpu_cs = 1'b0;
        cpu_r  = 1'b0;
`else
        chk("starve_stall_count", stall_cnt, 32'd0);
        chk("starve_no_ack", ack_at, 32'd0);
        step();
        cpu_cs = 1'b0;
        cpu_r  = 1'b0;
        p1_wait_ack(5, lat);
        chk("starve_release_latency", lat, 32'd2);
`endif

        // Streaming: p1_req held for six cycles gives three accesses.
        step();
        p1_issue(1'b0, 11'h0C0, '0);
        exp_q.push_back(last_read);
        exp_q.push_back(last_read);
        pattern = '0;
        acks    = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pattern = {pattern[4:0], p1_ack};
            if (p1_ack) acks++;
            if (i == 5) p1_req = 1'b0;
        end
        chk("stream_ack_pattern", {26'b0, pattern}, 32'b010101);
        chk("stream_ack_count", acks, 32'd3);

        // Randomized concurrent traffic: CPU in the upper half, p1 in a small lower window.
        fork
            cpu_rand();
            begin
                p1_rand();
                rand_done = 1'b1;
            end
        join

        repeat (3) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
